// File: rtl/ddfs_channel_scheduler.sv
// Round-robin DDFS scheduler sharing one registered sine ROM across NUM_CH channels; 3-cycle issue-to-sample latency.
// Optional quarter-wave ROM folding enabled by defining DDFS_QUARTER_WAVE_EN.
module ddfs_channel_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  localparam int SW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [NUM_CH-1:0]             ch_en,
  input  logic [NUM_CH*PHASE_WIDTH-1:0] fccw,
  input  logic [NUM_CH*PHASE_WIDTH-1:0] pha,
  output logic [ADDR_WIDTH-1:0]         rom_addr_o,
  input  logic [DATA_WIDTH-1:0]         rom_data_i,
  output logic [DATA_WIDTH-1:0]         sample_o,
  output logic [SW-1:0]                 sample_ch_o,
  output logic                          sample_valid_o,
  output logic                          frame_o
);

`ifdef DDFS_QUARTER_WAVE_EN
  localparam int IW = ADDR_WIDTH + 2;
`else
  localparam int IW = ADDR_WIDTH;
`endif
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CH - 1);

  logic [SW-1:0]          slot;
  logic [PHASE_WIDTH-1:0] acc [NUM_CH];

  logic [PHASE_WIDTH-1:0] acc_cur;
  logic [PHASE_WIDTH-1:0] fccw_cur;
  logic [PHASE_WIDTH-1:0] pha_cur;
  logic                   chen_cur;
  logic [IW-1:0]          phase_idx;
  logic [ADDR_WIDTH-1:0]  addr_next;

  logic [SW-1:0] tag1, tag2;
  logic          vld1, vld2;
  logic          frame1, frame2;

  // Select the current slot's channel state and controls.
  always_comb begin
    acc_cur  = '0;
    fccw_cur = '0;
    pha_cur  = '0;
    chen_cur = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (slot == SW'(c)) begin
        acc_cur  = acc[c];
        fccw_cur = fccw[c*PHASE_WIDTH +: PHASE_WIDTH];
        pha_cur  = pha[c*PHASE_WIDTH +: PHASE_WIDTH];
        chen_cur = ch_en[c];
      end
    end
  end

  always_comb begin
    phase_idx = IW'((acc_cur + pha_cur) >> (PHASE_WIDTH - IW));
`ifdef DDFS_QUARTER_WAVE_EN
    // Odd quadrants read the quarter table backwards.
    addr_next = phase_idx[ADDR_WIDTH] ? ~phase_idx[ADDR_WIDTH-1:0]
                                      : phase_idx[ADDR_WIDTH-1:0];
`else
    addr_next = phase_idx;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
    end else if (en) begin
      slot <= (slot == LAST_SLOT) ? '0 : slot + SW'(1);
    end
  end

  // Only the owning slot touches an accumulator; a disabled channel restarts from zero.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        acc[c] <= '0;
      end else if (en && (slot == SW'(c))) begin
        acc[c] <= ch_en[c] ? acc[c] + fccw_cur : '0;
      end
    end
  end

  // Stage 1: address issue alongside tag, valid and frame marker.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_o <= '0;
      tag1       <= '0;
      vld1       <= 1'b0;
      frame1     <= 1'b0;
    end else if (en) begin
      rom_addr_o <= addr_next;
      tag1       <= slot;
      vld1       <= chen_cur;
      frame1     <= (slot == LAST_SLOT);
    end else begin
      vld1       <= 1'b0;
      frame1     <= 1'b0;
    end
  end

  // Stage 2 covers the ROM read latency; stage 3 registers the sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag2           <= '0;
      vld2           <= 1'b0;
      frame2         <= 1'b0;
      sample_ch_o    <= '0;
      sample_valid_o <= 1'b0;
      frame_o        <= 1'b0;
    end else begin
      tag2           <= tag1;
      vld2           <= vld1;
      frame2         <= frame1;
      sample_ch_o    <= tag2;
      sample_valid_o <= vld2;
      frame_o        <= frame2;
    end
  end

`ifdef DDFS_QUARTER_WAVE_EN
  logic neg1, neg2;

  always_ff @(posedge clk) begin
    if (reset) begin
      neg1     <= 1'b0;
      neg2     <= 1'b0;
      sample_o <= '0;
    end else begin
      if (en) begin
        neg1 <= phase_idx[ADDR_WIDTH+1];
      end
      neg2     <= neg1;
      sample_o <= neg2 ? DATA_WIDTH'(-rom_data_i) : rom_data_i;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_o <= '0;
    end else begin
      sample_o <= rom_data_i;
    end
  end
`endif

endmodule

// File: tb/tb_ddfs_channel_scheduler.sv
// Directed bench for ddfs_channel_scheduler with a registered ROM model returning its address.
module tb_ddfs_channel_scheduler;
  localparam int NUM_CH = 4;
  localparam int PW     = 32;
  localparam int AW     = 10;
  localparam int DW     = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 en;
  logic [NUM_CH-1:0]    ch_en;
  logic [NUM_CH*PW-1:0] fccw;
  logic [NUM_CH*PW-1:0] pha;
  logic [AW-1:0]        rom_addr;
  logic [DW-1:0]        rom_data;
  logic [DW-1:0]        sample;
  logic [1:0]           sample_ch;
  logic                 sample_valid;
  logic                 frame;

  int n_assert = 0;
  int n_fail   = 0;

  ddfs_channel_scheduler #(
    .NUM_CH(NUM_CH), .PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .ch_en(ch_en), .fccw(fccw), .pha(pha),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data), .sample_o(sample),
    .sample_ch_o(sample_ch), .sample_valid_o(sample_valid), .frame_o(frame)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= {{(DW-AW){1'b0}}, rom_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  32'(rom_addr), 0);
    chk({tag, "_smp"},   32'(sample), 0);
    chk({tag, "_ch"},    32'(sample_ch), 0);
    chk({tag, "_vld"},   32'(sample_valid), 0);
    chk({tag, "_frame"}, 32'(frame), 0);
  endtask

  initial begin
    int vcyc [7];
    int k;
    int idx;
    logic [15:0] exp_s;
    logic exp_v;

    reset = 1'b1;
    en    = 1'b1;
    ch_en = 4'b0001;
    fccw  = '0;
    pha   = '0;
    fccw[0*PW +: PW] = 32'h0040_0000;

    // Reset state, then single-channel stepping with frame pulses.
    tick();
    chk_all_zero("rst");
    reset = 1'b0;
    for (int n = 0; n <= 16; n++) begin
      exp_v = (n >= 3) && ((n - 3) % 4 == 0);
      chk("t1_vld", 32'(sample_valid), 32'(exp_v));
      if (exp_v) begin
        chk("t1_smp", 32'(sample), (n - 3) / 4);
        chk("t1_ch", 32'(sample_ch), 0);
      end
      chk("t1_frame", 32'(frame), 32'((n >= 6) && ((n - 6) % 4 == 0)));
      chk("t1_addr", 32'(rom_addr), (n % 4 == 1) ? (n - 1) / 4 : 0);
      tick();
    end

    // All channels enabled: tags rotate on every valid cycle.
    ch_en = 4'b1111;
    fccw  = '0;
    pha   = '0;
    fccw[0*PW +: PW] = 32'h8000_0000;
    fccw[1*PW +: PW] = 32'h0040_0000;
    pha[1*PW +: PW]  = 32'h4000_0000;
    pulse_reset();
    for (int n = 0; n <= 14; n++) begin
      if (n < 3) begin
        chk("t2_vld0", 32'(sample_valid), 0);
      end else begin
        k = n - 3;
        case (k % 4)
          0:       exp_s = ((k / 4) % 2 == 1) ? 16'd512 : 16'd0;
          1:       exp_s = 16'(256 + k / 4);
          default: exp_s = 16'd0;
        endcase
        chk("t2_vld", 32'(sample_valid), 1);
        chk("t2_ch", 32'(sample_ch), k % 4);
        chk("t2_smp", 32'(sample), 32'(exp_s));
        chk("t2_frame", 32'(frame), 32'(k % 4 == 3));
      end
      tick();
    end

    // Global pause: in-flight slot drains, phase resumes without a gap.
    ch_en = 4'b0001;
    fccw  = '0;
    pha   = '0;
    fccw[0*PW +: PW] = 32'h0040_0000;
    vcyc = '{3, 7, 11, 15, 24, 28, 32};
    pulse_reset();
    for (int n = 0; n <= 33; n++) begin
      en = !((n >= 13) && (n <= 17));
      idx = -1;
      for (int i = 0; i < 7; i++) if (vcyc[i] == n) idx = i;
      chk("t3_vld", 32'(sample_valid), 32'(idx >= 0));
      if (idx >= 0) chk("t3_smp", 32'(sample), idx);
      tick();
    end
    en = 1'b1;

    // One frame with channel 0 disabled restarts it at phase 0 + offset.
    pha[0*PW +: PW] = 32'h0080_0000;
    pulse_reset();
    for (int n = 0; n <= 16; n++) begin
      ch_en[0] = !((n >= 4) && (n <= 7));
      exp_v = (n == 3) || (n == 11) || (n == 15);
      chk("t4_vld", 32'(sample_valid), 32'(exp_v));
      if (exp_v) chk("t4_smp", 32'(sample), (n == 15) ? 3 : 2);
      tick();
    end
    ch_en = 4'b0001;

    // Mid-stream reset flushes the pipeline.
    pha = '0;
    pulse_reset();
    for (int n = 0; n <= 9; n++) begin
      exp_v = (n == 3) || (n == 7);
      chk("t5_pre_vld", 32'(sample_valid), 32'(exp_v));
      if (exp_v) chk("t5_pre_smp", 32'(sample), (n == 7) ? 1 : 0);
      tick();
    end
    pulse_reset();
    chk_all_zero("t5_rst");
    for (int m = 0; m <= 7; m++) begin
      exp_v = (m == 3) || (m == 7);
      chk("t5_vld", 32'(sample_valid), 32'(exp_v));
      if (exp_v) chk("t5_smp", 32'(sample), (m == 7) ? 1 : 0);
      tick();
    end

`ifdef DDFS_QUARTER_WAVE_EN
    begin
      int qidx [4];
      int qaddr [4];
      logic [15:0] qsmp [4];
      qidx  = '{1, 1025, 2049, 3073};
      qaddr = '{1, 1022, 1, 1022};
      qsmp  = '{16'h0001, 16'h03FE, 16'hFFFF, 16'hFC02};
      fccw[0*PW +: PW] = 32'h0010_0000;
      for (int i = 0; i < 4; i++) begin
        pha[0*PW +: PW] = 32'(qidx[i]) << 20;
        pulse_reset();
        tick();
        chk("t6_addr", 32'(rom_addr), qaddr[i]);
        tick();
        tick();
        chk("t6_vld", 32'(sample_valid), 1);
        chk("t6_smp", 32'(sample), 32'(qsmp[i]));
      end
    end
`else
    begin
      int fidx [4];
      fidx = '{1, 511, 512, 1023};
      fccw[0*PW +: PW] = 32'h0040_0000;
      for (int i = 0; i < 4; i++) begin
        pha[0*PW +: PW] = 32'(fidx[i]) << 22;
        pulse_reset();
        tick();
        chk("t6_addr", 32'(rom_addr), fidx[i]);
        tick();
        tick();
        chk("t6_vld", 32'(sample_valid), 1);
        chk("t6_smp", 32'(sample), fidx[i]);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
